// File: rtl/riscv_pkg.sv
// riscv_pkg: opcodes, ALUOp values, ALU control codes and immediate kinds
// shared by the decode stage.
package riscv_pkg;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   typedef enum logic [1:0] {ALUOP_MEM = 2'b00, ALUOP_BR = 2'b01, ALUOP_RI = 2'b10} aluop_e;
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   typedef enum logic [1:0] {IMM_NONE, IMM_I, IMM_S, IMM_B} imm_e;
   // Returns {supported, alu_ctrl}; funct7 only qualifies R-type encodings.
   function automatic logic [4:0] alu_decode(input aluop_e op, input logic r, input logic [2:0] f3,
                                             input logic [6:0] f7);
      logic base;
      base = !r || f7 == 7'b0000000;
      return op == ALUOP_MEM ? {1'b1, ALU_ADD} :
             op == ALUOP_BR ? {1'b1, ALU_SUB} :
             f3 == 3'b000 && base ? {1'b1, ALU_ADD} :
             f3 == 3'b000 && r && f7 == 7'b0100000 ? {1'b1, ALU_SUB} :
             f3 == 3'b111 && base ? {1'b1, ALU_AND} :
             f3 == 3'b110 && base ? {1'b1, ALU_OR} : {1'b0, ALU_ADD};
   endfunction
endpackage

// File: rtl/regfile.sv
// regfile: NREG x XLEN registers, two read ports with write-through bypass,
// x0 hardwired to zero.
module regfile #(
   parameter int XLEN = 64,
   parameter int NREG = 32,
   parameter bit RF_RESET = 1'b1,
   localparam int AW = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [AW-1:0]   ra1,
   input  logic [AW-1:0]   ra2,
   output logic [XLEN-1:0] rd1,
   output logic [XLEN-1:0] rd2,
   input  logic            we,
   input  logic [AW-1:0]   wa,
   input  logic [XLEN-1:0] wd
);
   logic [XLEN-1:0] regs [NREG];
   always_ff @(posedge clk) begin
      if (rst && RF_RESET) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (we && wa != '0) begin
         regs[wa] <= wd;
      end
   end
   assign rd1 = ra1 == '0 ? '0 : we && wa == ra1 ? wd : regs[ra1];
   assign rd2 = ra2 == '0 ? '0 : we && wa == ra2 ? wd : regs[ra2];
endmodule

// File: rtl/decode_stage.sv
// decode_stage: RISC-V decode with register file read, load-use stall,
// flush and a valid/ready ID/EX pipeline register.
module decode_stage
   import riscv_pkg::*;
#(
   parameter int XLEN = 64,
   parameter int NREG = 32,
   parameter bit RF_RESET = 1'b1,
   localparam int AW = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            if_valid,
   output logic            if_ready,
   input  logic [31:0]     if_instr,
   input  logic [XLEN-1:0] if_pc,
   input  logic            wb_we,
   input  logic [AW-1:0]   wb_addr,
   input  logic [XLEN-1:0] wb_data,
   input  logic            flush,
   output logic            id_valid,
   input  logic            id_ready,
   output logic [XLEN-1:0] id_rd1,
   output logic [XLEN-1:0] id_rd2,
   output logic [XLEN-1:0] id_store_data,
   output logic [XLEN-1:0] id_imm,
   output logic [XLEN-1:0] id_pc,
   output logic [AW-1:0]   id_rd,
   output logic [3:0]      id_alu_ctrl,
   output logic            id_regwrite,
   output logic            id_memread,
   output logic            id_memwrite,
   output logic            id_memtoreg,
   output logic            id_branch,
   output logic            id_illegal
);
   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] rd1, rd2, sd, imm, pc;
      logic [AW-1:0]   rd;
      logic [3:0]      alu;
      logic            regwrite, memread, memwrite, memtoreg, branch, illegal;
   } idex_t;
   idex_t r, d, q;
   logic [6:0] opc;
   logic [AW-1:0] rs1, rs2;
   logic [XLEN-1:0] rf1, rf2, imm;
   aluop_e aluop;
   imm_e imm_t;
   logic [3:0] alu;
   logic alusrc, regwrite, memread, memwrite, memtoreg, branch, bad_op, use_rs1, use_rs2;
   logic alu_ok, illegal, hazard, load_en;
   assign opc = if_instr[6:0];
   assign rs1 = if_instr[15 +: AW];
   assign rs2 = if_instr[20 +: AW];
   regfile #(.XLEN(XLEN), .NREG(NREG), .RF_RESET(RF_RESET)) u_rf (
      .clk(clk), .rst(rst), .ra1(rs1), .ra2(rs2), .rd1(rf1), .rd2(rf2),
      .we(wb_we), .wa(wb_addr), .wd(wb_data)
   );
   always_comb begin
      aluop = ALUOP_MEM;
      imm_t = IMM_NONE;
      {alusrc, regwrite, memread, memwrite, memtoreg, branch, bad_op, use_rs2} = '0;
      use_rs1 = 1'b1;
      case (opc)
         OP_R:      {aluop, regwrite, use_rs2} = {ALUOP_RI, 2'b11};
         OP_I:      {aluop, imm_t, alusrc, regwrite} = {ALUOP_RI, IMM_I, 2'b11};
         OP_LOAD:   {imm_t, alusrc, regwrite, memread, memtoreg} = {IMM_I, 4'b1111};
         OP_STORE:  {imm_t, alusrc, memwrite, use_rs2} = {IMM_S, 3'b111};
         OP_BRANCH: {aluop, imm_t, branch, use_rs2} = {ALUOP_BR, IMM_B, 2'b11};
         default:   {bad_op, use_rs1} = 2'b10;
      endcase
   end
   assign {alu_ok, alu} = alu_decode(aluop, opc == OP_R, if_instr[14:12], if_instr[31:25]);
   assign illegal = bad_op || !alu_ok;
   assign imm = imm_t == IMM_I ? {{(XLEN-12){if_instr[31]}}, if_instr[31:20]} :
                imm_t == IMM_S ? {{(XLEN-12){if_instr[31]}}, if_instr[31:25], if_instr[11:7]} :
                imm_t == IMM_B ? {{(XLEN-13){if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25],
                                  if_instr[11:8], 1'b0} : '0;
   always_comb begin
      d.valid = 1'b1;
      d.rd1 = rf1;
      d.rd2 = alusrc ? imm : rf2;
      d.sd = rf2;
      d.imm = imm;
      d.pc = if_pc;
      d.rd = if_instr[7 +: AW];
      d.alu = alu;
      d.regwrite = regwrite && !illegal;
      d.memread = memread && !illegal;
      d.memwrite = memwrite && !illegal;
      d.memtoreg = memtoreg && !illegal;
      d.branch = branch && !illegal;
      d.illegal = illegal;
   end
   // A load in ID/EX cannot forward its data yet, so a dependent instruction waits one cycle.
   assign hazard = r.valid && r.memread && r.rd != '0 &&
                   ((use_rs1 && r.rd == rs1) || (use_rs2 && r.rd == rs2));
   assign load_en = !r.valid || id_ready;
   assign if_ready = load_en && !hazard && !flush && !rst;
   always_ff @(posedge clk) begin
      if (rst) r <= '0;
      else if (flush || load_en) r <= if_valid && if_ready ? d : '0;
   end
   assign q = rst ? '0 : r;
   assign id_valid = q.valid;
   assign id_rd1 = q.rd1;
   assign id_rd2 = q.rd2;
   assign id_store_data = q.sd;
   assign id_imm = q.imm;
   assign id_pc = q.pc;
   assign id_rd = q.rd;
   assign id_alu_ctrl = q.alu;
   assign id_regwrite = q.regwrite;
   assign id_memread = q.memread;
   assign id_memwrite = q.memwrite;
   assign id_memtoreg = q.memtoreg;
   assign id_branch = q.branch;
   assign id_illegal = q.illegal;
endmodule
